// File: rtl/pong_engine.sv
// pong_engine: two-player pong on the VGA pixel stream (paddles, ball, scoring, serve/play/over FSM).
// Optional build macro PONG_SPEEDUP_EN: each paddle hit raises the ball step by one, up to BALL_STEP_MAX.
module pong_engine #(
    parameter int COORD_W         = 10,
    parameter int H_ACTIVE        = 800,
    parameter int V_ACTIVE        = 600,
    parameter int PADDLE_W        = 100,
    parameter int PADDLE_H        = 20,
    parameter int PADDLE_STEP     = 20,
    parameter int BALL_SIZE       = 16,
    parameter int BALL_STEP       = 8,
    parameter int BALL_STEP_MAX   = 24,
    parameter int FRAMES_PER_TICK = 2,
    parameter int SERVE_TICKS     = 30,
    parameter int WIN_SCORE       = 7,
    parameter int SCORE_W         = 4
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               p1_left,
    input  logic               p1_right,
    input  logic               p2_left,
    input  logic               p2_right,
    input  logic [COORD_W-1:0] h_coord,
    input  logic [COORD_W-1:0] v_coord,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         game_state,
    output logic               winner
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3} state_t;
    typedef logic signed [COORD_W:0] spos_t;
    typedef logic [COORD_W-1:0]      coord_t;

    localparam int FC_W   = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam int SC_W   = $clog2(SERVE_TICKS + 1);
    localparam int STEP_W = $clog2(BALL_STEP_MAX + 1);

    localparam spos_t ZERO       = '0;
    localparam spos_t PW         = spos_t'(PADDLE_W);
    localparam spos_t PH         = spos_t'(PADDLE_H);
    localparam spos_t BSZ        = spos_t'(BALL_SIZE);
    localparam spos_t PSTEP      = spos_t'(PADDLE_STEP);
    localparam spos_t PAD_MAX    = spos_t'(H_ACTIVE - PADDLE_W);
    localparam spos_t PAD_CENTRE = spos_t'((H_ACTIVE - PADDLE_W) / 2);
    localparam spos_t BALL_X_MAX = spos_t'(H_ACTIVE - BALL_SIZE);
    localparam spos_t BALL_X0    = spos_t'((H_ACTIVE - BALL_SIZE) / 2);
    localparam spos_t BALL_Y0    = spos_t'((V_ACTIVE - BALL_SIZE) / 2);
    localparam spos_t BOT_HIT_Y  = spos_t'(V_ACTIVE - PADDLE_H - BALL_SIZE);
    localparam spos_t BOT_MISS_Y = spos_t'(V_ACTIVE - BALL_SIZE);
    localparam spos_t P2_Y       = spos_t'(V_ACTIVE - PADDLE_H);
    localparam spos_t H_END      = spos_t'(H_ACTIVE);
    localparam spos_t V_END      = spos_t'(V_ACTIVE);
    localparam coord_t H_LAST    = coord_t'(H_ACTIVE - 1);
    localparam coord_t V_LAST    = coord_t'(V_ACTIVE - 1);

    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [FC_W-1:0]    FC_LAST = FC_W'(FRAMES_PER_TICK - 1);
    localparam logic [SC_W-1:0]    SC_LAST = SC_W'(SERVE_TICKS - 1);
    localparam logic [STEP_W-1:0]  STEP0   = STEP_W'(BALL_STEP);

    state_t              state;
    logic                eof_r;
    logic [FC_W-1:0]     frame_cnt;
    logic [SC_W-1:0]     serve_cnt;
    spos_t               p1_x, p2_x, ball_x, ball_y;
    logic                dx_pos, dy_pos;
    logic [STEP_W-1:0]   step;

    logic                tick;
    spos_t               step_s, bx_try, by_try, bx_new, by_new, p1_new, p2_new;
    logic                dx_new, dy_new, over_p1, over_p2, hit, p1_scores, p2_scores;
    logic [STEP_W-1:0]   step_hit, step_new;
    logic [SCORE_W-1:0]  s1_inc, s2_inc;
    spos_t               hs, vs;
    logic                on_ball, on_p1, on_p2, active;
    logic [11:0]         pix;

    assign game_state = state;

    function automatic spos_t paddle_next(spos_t x, logic left, logic right);
        spos_t t;
        t = x;
        if (left) begin
            t = x - PSTEP;
            if (t < ZERO) t = ZERO;
        end else if (right) begin
            t = x + PSTEP;
            if (t > PAD_MAX) t = PAD_MAX;
        end
        return t;
    endfunction

    // Game physics for one tick; overlap uses pre-move ball and paddle positions.
    always_comb begin
        tick    = eof_r && (frame_cnt == '0);
        step_s  = spos_t'(step);
        p1_new  = paddle_next(p1_x, p1_left, p1_right);
        p2_new  = paddle_next(p2_x, p2_left, p2_right);
        over_p1 = (ball_x < p1_x + PW) && (ball_x + BSZ > p1_x);
        over_p2 = (ball_x < p2_x + PW) && (ball_x + BSZ > p2_x);
        bx_try  = dx_pos ? ball_x + step_s : ball_x - step_s;
        by_try  = dy_pos ? ball_y + step_s : ball_y - step_s;
        bx_new  = bx_try;
        dx_new  = dx_pos;
        if (bx_try < ZERO) begin
            bx_new = ZERO;
            dx_new = 1'b1;
        end else if (bx_try > BALL_X_MAX) begin
            bx_new = BALL_X_MAX;
            dx_new = 1'b0;
        end
        by_new    = by_try;
        dy_new    = dy_pos;
        hit       = 1'b0;
        p1_scores = 1'b0;
        p2_scores = 1'b0;
        if (!dy_pos) begin
            if (by_try <= PH && over_p1) begin
                by_new = PH;
                dy_new = 1'b1;
                hit    = 1'b1;
            end else if (by_try <= ZERO) begin
                p2_scores = 1'b1;
            end
        end else begin
            if (by_try >= BOT_HIT_Y && over_p2) begin
                by_new = BOT_HIT_Y;
                dy_new = 1'b0;
                hit    = 1'b1;
            end else if (by_try >= BOT_MISS_Y) begin
                p1_scores = 1'b1;
            end
        end
`ifdef PONG_SPEEDUP_EN
        step_hit = (step < STEP_W'(BALL_STEP_MAX)) ? step + 1'b1 : step;
`else
        step_hit = step;
`endif
        step_new = hit ? step_hit : step;
        s1_inc   = score1 + 1'b1;
        s2_inc   = score2 + 1'b1;
    end

    // Half-open rectangle hit tests for the current pixel.
    always_comb begin
        hs      = $signed({1'b0, h_coord});
        vs      = $signed({1'b0, v_coord});
        active  = (hs < H_END) && (vs < V_END);
        on_ball = (state != S_IDLE) && (hs >= ball_x) && (hs < ball_x + BSZ)
                  && (vs >= ball_y) && (vs < ball_y + BSZ);
        on_p1   = (hs >= p1_x) && (hs < p1_x + PW) && (vs < PH);
        on_p2   = (hs >= p2_x) && (hs < p2_x + PW) && (vs >= P2_Y) && (vs < P2_Y + PH);
        pix     = 12'h000;
        if (active) begin
            if (on_ball)    pix = 12'hFFF;
            else if (on_p1) pix = 12'hF00;
            else if (on_p2) pix = 12'h00F;
        end
    end

    // start is a single-cycle pulse with no handshake: it is acted on in the cycle it is
    // seen while in IDLE or OVER and ignored in every other state.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            eof_r              <= 1'b0;
            frame_cnt          <= '0;
            serve_cnt          <= '0;
            p1_x               <= PAD_CENTRE;
            p2_x               <= PAD_CENTRE;
            ball_x             <= BALL_X0;
            ball_y             <= BALL_Y0;
            dx_pos             <= 1'b1;
            dy_pos             <= 1'b1;
            step               <= STEP0;
            score1             <= '0;
            score2             <= '0;
            winner             <= 1'b0;
            {red, green, blue} <= 12'h000;
        end else begin
            eof_r              <= (h_coord == H_LAST) && (v_coord == V_LAST);
            {red, green, blue} <= pix;
            if (eof_r) frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state     <= S_SERVE;
                        serve_cnt <= '0;
                        ball_x    <= BALL_X0;
                        ball_y    <= BALL_Y0;
                        step      <= STEP0;
                        if (state == S_OVER) begin
                            score1 <= '0;
                            score2 <= '0;
                            p1_x   <= PAD_CENTRE;
                            p2_x   <= PAD_CENTRE;
                        end
                    end
                end
                S_SERVE: begin
                    if (tick) begin
                        p1_x <= p1_new;
                        p2_x <= p2_new;
                        if (serve_cnt == SC_LAST) state <= S_PLAY;
                        else serve_cnt <= serve_cnt + 1'b1;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        p1_x   <= p1_new;
                        p2_x   <= p2_new;
                        ball_x <= bx_new;
                        dx_pos <= dx_new;
                        if (p1_scores || p2_scores) begin
                            if (p1_scores) score1 <= s1_inc;
                            else           score2 <= s2_inc;
                            if ((p1_scores ? s1_inc : s2_inc) == WIN) begin
                                state  <= S_OVER;
                                winner <= p2_scores;
                            end else begin
                                // Serve toward whoever conceded.
                                state     <= S_SERVE;
                                serve_cnt <= '0;
                                ball_x    <= BALL_X0;
                                ball_y    <= BALL_Y0;
                                dy_pos    <= p1_scores;
                                step      <= STEP0;
                            end
                        end else begin
                            ball_y <= by_new;
                            dy_pos <= dy_new;
                            step   <= step_new;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: drives eof pulses as game ticks and probes pixels to locate objects.
module tb_pong_engine;

    localparam logic [11:0] WHITE = 12'hFFF;
    localparam logic [11:0] RED   = 12'hF00;
    localparam logic [11:0] BLUE  = 12'h00F;
    localparam logic [11:0] BLACK = 12'h000;

    logic       pixel_clk = 1'b0;
    logic       rst_n, start, p1_left, p1_right, p2_left, p2_right;
    logic [9:0] h_coord, v_coord;
    logic [3:0] red, green, blue;
    logic [3:0] score1, score2;
    logic [1:0] game_state;
    logic       winner;

    int tests  = 0;
    int failed = 0;

    always #5 pixel_clk = ~pixel_clk;

    pong_engine dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .start     (start),
        .p1_left   (p1_left),
        .p1_right  (p1_right),
        .p2_left   (p2_left),
        .p2_right  (p2_right),
        .h_coord   (h_coord),
        .v_coord   (v_coord),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .score1    (score1),
        .score2    (score2),
        .game_state(game_state),
        .winner    (winner)
    );

    task automatic cycle();
        @(posedge pixel_clk);
        #1;
    endtask

    // One frame: a single end-of-frame coordinate, then an off-screen one while the update lands.
    task automatic do_frame();
        h_coord = 10'd799;
        v_coord = 10'd599;
        cycle();
        h_coord = 10'd1000;
        v_coord = 10'd1000;
        cycle();
    endtask

    task automatic do_ticks(input int n);
        for (int t = 0; t < n; t++) begin
            do_frame();
            do_frame();
        end
    endtask

    task automatic probe(input int x, input int y, output logic [11:0] rgb);
        h_coord = 10'(x);
        v_coord = 10'(y);
        cycle();
        rgb = {red, green, blue};
        h_coord = 10'd1000;
        v_coord = 10'd1000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        int px[9] = '{350, 449, 450, 349, 350, 449, 350, 392, 820};
        int py[9] = '{0, 19, 0, 0, 580, 599, 579, 292, 10};
        logic [11:0] ex[9] = '{RED, RED, BLACK, BLACK, BLUE, BLUE, BLACK, BLACK, BLACK};
        logic [11:0] got;
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        tests++;
        if (game_state !== 2'd0 || score1 !== 4'd0 || score2 !== 4'd0 || winner !== 1'b0) begin
            failed++;
            $display("FAIL reset_regs: state=%0d s1=%0d s2=%0d win=%0d, required 0 0 0 0",
                     game_state, score1, score2, winner);
        end
        foreach (px[i]) begin
            probe(px[i], py[i], got);
            tests++;
            if (got !== ex[i]) begin
                failed++;
                $display("FAIL reset_pixel(%0d,%0d): got %h required %h", px[i], py[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_start();
        int px[5] = '{392, 407, 408, 400, 391};
        int py[5] = '{292, 307, 300, 308, 300};
        logic [11:0] ex[5] = '{WHITE, WHITE, BLACK, BLACK, BLACK};
        logic [11:0] got;
        pulse_start();
        tests++;
        if (game_state !== 2'd1) begin
            failed++;
            $display("FAIL start_to_serve: state=%0d required 1", game_state);
        end
        foreach (px[i]) begin
            probe(px[i], py[i], got);
            tests++;
            if (got !== ex[i]) begin
                failed++;
                $display("FAIL serve_ball(%0d,%0d): got %h required %h", px[i], py[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_paddle_clamp();
        int px[7] = '{0, 99, 100, 590, 589, 689, 690};
        int py[7] = '{0, 19, 0, 580, 580, 599, 599};
        logic [11:0] ex[7] = '{RED, RED, BLACK, BLUE, BLACK, BLUE, BLACK};
        logic [11:0] got;
        p1_left  = 1'b1;
        p2_right = 1'b1;
        do_ticks(12);
        p2_right = 1'b0;
        do_ticks(8);
        foreach (px[i]) begin
            probe(px[i], py[i], got);
            tests++;
            if (got !== ex[i]) begin
                failed++;
                $display("FAIL paddle_clamp(%0d,%0d): got %h required %h", px[i], py[i], got, ex[i]);
            end
        end
        p1_right = 1'b1;
        do_ticks(1);
        p1_left  = 1'b0;
        p1_right = 1'b0;
        probe(0, 0, got);
        tests++;
        if (got !== RED) begin
            failed++;
            $display("FAIL left_priority(0,0): got %h required %h", got, RED);
        end
        probe(100, 0, got);
        tests++;
        if (got !== BLACK) begin
            failed++;
            $display("FAIL left_priority(100,0): got %h required %h", got, BLACK);
        end
    endtask

    task automatic test_serve_to_play();
        int px[5] = '{392, 407, 408, 392, 391};
        int py[5] = '{292, 307, 292, 308, 292};
        logic [11:0] ex[5] = '{WHITE, WHITE, BLACK, BLACK, BLACK};
        logic [11:0] got;
        do_ticks(8);
        tests++;
        if (game_state !== 2'd1) begin
            failed++;
            $display("FAIL serve_29_ticks: state=%0d required 1", game_state);
        end
        do_ticks(1);
        tests++;
        if (game_state !== 2'd2) begin
            failed++;
            $display("FAIL serve_30_ticks: state=%0d required 2", game_state);
        end
        foreach (px[i]) begin
            probe(px[i], py[i], got);
            tests++;
            if (got !== ex[i]) begin
                failed++;
                $display("FAIL play_ball(%0d,%0d): got %h required %h", px[i], py[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_ball_motion();
        int px[4] = '{400, 399, 415, 416};
        int py[4] = '{300, 300, 315, 315};
        logic [11:0] ex[4] = '{WHITE, BLACK, WHITE, BLACK};
        logic [11:0] got;
        do_ticks(1);
        foreach (px[i]) begin
            probe(px[i], py[i], got);
            tests++;
            if (got !== ex[i]) begin
                failed++;
                $display("FAIL ball_step(%0d,%0d): got %h required %h", px[i], py[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_paddle_bounce();
        int px[8] = '{664, 679, 664, 664, 672, 687, 672, 688};
        int py[8] = '{564, 579, 580, 563, 556, 571, 572, 556};
        logic [11:0] ex[8] = '{WHITE, WHITE, BLUE, BLACK, WHITE, WHITE, BLACK, BLACK};
        logic [11:0] got;
        // ball reaches y=564 on the 34th play tick with P2 at x=590 under it
        do_ticks(33);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) do_ticks(1);
            probe(px[i], py[i], got);
            tests++;
            if (got !== ex[i]) begin
                failed++;
                $display("FAIL bounce(%0d,%0d): got %h required %h", px[i], py[i], got, ex[i]);
            end
        end
        tests++;
        if (game_state !== 2'd2 || score1 !== 4'd0 || score2 !== 4'd0) begin
            failed++;
            $display("FAIL bounce_no_score: state=%0d s1=%0d s2=%0d, required 2 0 0",
                     game_state, score1, score2);
        end
    endtask

    task automatic test_reset_mid_play();
        int px[5] = '{350, 0, 350, 590, 672};
        int py[5] = '{0, 0, 580, 580, 556};
        logic [11:0] ex[5] = '{RED, BLACK, BLUE, BLACK, BLACK};
        logic [11:0] got;
        h_coord = 10'd350;
        v_coord = 10'd0;
        rst_n   = 1'b0;
        start   = 1'b1;
        cycle();
        rst_n = 1'b1;
        start = 1'b0;
        tests++;
        if (game_state !== 2'd0 || score1 !== 4'd0 || {red, green, blue} !== BLACK) begin
            failed++;
            $display("FAIL mid_reset: state=%0d s1=%0d rgb=%h, required 0 0 000",
                     game_state, score1, {red, green, blue});
        end
        foreach (px[i]) begin
            probe(px[i], py[i], got);
            tests++;
            if (got !== ex[i]) begin
                failed++;
                $display("FAIL mid_reset_pixel(%0d,%0d): got %h required %h", px[i], py[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_scoring();
        logic [11:0] got;
        pulse_start();
        p2_left = 1'b1;
        do_ticks(30);
        p2_left = 1'b0;
        tests++;
        if (game_state !== 2'd2) begin
            failed++;
            $display("FAIL score_serve_done: state=%0d required 2", game_state);
        end
        probe(0, 580, got);
        tests++;
        if (got !== BLUE) begin
            failed++;
            $display("FAIL p2_at_zero: got %h required %h", got, BLUE);
        end
        do_ticks(36);
        tests++;
        if (game_state !== 2'd2 || score1 !== 4'd0) begin
            failed++;
            $display("FAIL before_miss: state=%0d s1=%0d, required 2 0", game_state, score1);
        end
        do_ticks(1);
        tests++;
        if (game_state !== 2'd1 || score1 !== 4'd1 || score2 !== 4'd0) begin
            failed++;
            $display("FAIL p2_miss: state=%0d s1=%0d s2=%0d, required 1 1 0", game_state, score1, score2);
        end
        probe(392, 292, got);
        tests++;
        if (got !== WHITE) begin
            failed++;
            $display("FAIL recentre: got %h required %h", got, WHITE);
        end
    endtask

    task automatic test_game_over();
        logic [11:0] got;
        for (int pt = 2; pt <= 7; pt++) begin
            do_ticks(67);
            tests++;
            if (score1 !== 4'(pt) || game_state !== ((pt == 7) ? 2'd3 : 2'd1)) begin
                failed++;
                $display("FAIL point_%0d: s1=%0d state=%0d, required %0d %0d",
                         pt, score1, game_state, pt, (pt == 7) ? 3 : 1);
            end
        end
        tests++;
        if (winner !== 1'b0 || score2 !== 4'd0) begin
            failed++;
            $display("FAIL winner: winner=%0d s2=%0d, required 0 0", winner, score2);
        end
        do_ticks(3);
        tests++;
        if (game_state !== 2'd3 || score1 !== 4'd7) begin
            failed++;
            $display("FAIL over_frozen: state=%0d s1=%0d, required 3 7", game_state, score1);
        end
        pulse_start();
        tests++;
        if (game_state !== 2'd1 || score1 !== 4'd0 || score2 !== 4'd0) begin
            failed++;
            $display("FAIL restart: state=%0d s1=%0d s2=%0d, required 1 0 0", game_state, score1, score2);
        end
        probe(350, 580, got);
        tests++;
        if (got !== BLUE) begin
            failed++;
            $display("FAIL restart_p2_centre: got %h required %h", got, BLUE);
        end
        probe(0, 580, got);
        tests++;
        if (got !== BLACK) begin
            failed++;
            $display("FAIL restart_p2_left_edge: got %h required %h", got, BLACK);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        p1_left  = 1'b0;
        p1_right = 1'b0;
        p2_left  = 1'b0;
        p2_right = 1'b0;
        h_coord  = 10'd1000;
        v_coord  = 10'd1000;
        test_reset();
        test_start();
        test_paddle_clamp();
        test_serve_to_play();
        test_ball_motion();
        test_paddle_bounce();
        test_reset_mid_play();
        test_scoring();
        test_game_over();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
